// File: rtl/nn_pkg.sv
// Shared fixed-point defaults and state encodings for the ann modules.
// No ports: imported by the weight-update datapath and its multiplier.
package nn_pkg;

   localparam int NN_WIDTH = 32;
   localparam int NN_FRAC  = 24;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MUL_G = 2'd1,
      S_MUL_W = 2'd2,
      S_DONE  = 2'd3
   } wu_state_t;

endpackage

// File: rtl/fxp_mul_sat.sv
// Signed fixed-point multiply: full product, >>> FRAC, saturate to WIDTH.
// Ports: a, b operands; p saturated result; ovf high when p was clamped.
module fxp_mul_sat
   import nn_pkg::*;
#(
   parameter int WIDTH = NN_WIDTH,
   parameter int FRAC  = NN_FRAC
) (
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] p,
   output logic                    ovf
);

   localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic signed [2*WIDTH-1:0] full;
   logic signed [2*WIDTH-1:0] shr;
   logic        [WIDTH:0]     hi;

   assign full = a * b;
   // arithmetic shift truncates toward -inf
   assign shr  = full >>> FRAC;
   // result fits only if all bits above the sign are sign copies
   assign hi   = shr[2*WIDTH-1:WIDTH-1];
   assign ovf  = !((&hi) || (~|hi));
   assign p    = ovf ? (shr[2*WIDTH-1] ? SMIN : SMAX) : shr[WIDTH-1:0];

endmodule

// File: rtl/weight_update_seq.sv
// Sequential output-layer weight update: w' = w - lr*(dlto[o]*hd_a[h]).
// Ports: clk, rst (sync, low); i_start/i_lr/i_dlto/i_hd_a/i_w in;
//        o_w updated weights, o_busy, o_done pulse, o_sat sticky flag.
module weight_update_seq
   import nn_pkg::*;
#(
   parameter int N_HL_P = 3,
   parameter int N_OUT  = 2,
   parameter int WIDTH  = NN_WIDTH,
   parameter int FRAC   = NN_FRAC
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_start,
   input  logic [WIDTH-1:0]               i_lr,
   input  logic [N_OUT*WIDTH-1:0]         i_dlto,
   input  logic [N_HL_P*WIDTH-1:0]        i_hd_a,
   input  logic [N_HL_P*N_OUT*WIDTH-1:0]  i_w,
   output logic [N_HL_P*N_OUT*WIDTH-1:0]  o_w,
   output logic                           o_busy,
   output logic                           o_done,
   output logic                           o_sat
);

   localparam int NW = N_HL_P * N_OUT;
   localparam int KW = (NW > 1) ? $clog2(NW) : 1;
   localparam int HW = (N_HL_P > 1) ? $clog2(N_HL_P) : 1;
   localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   wu_state_t state, state_nx;

   logic [KW-1:0] k;
   logic [HW-1:0] h;
   logic [OW-1:0] o;

   logic signed [WIDTH-1:0] lr_q;
   logic signed [WIDTH-1:0] g_q;
   logic signed [WIDTH-1:0] dlto_q [N_OUT];
   logic signed [WIDTH-1:0] hd_q   [N_HL_P];
   logic signed [WIDTH-1:0] w_q    [NW];
   logic                    sat_q;

   logic signed [WIDTH-1:0] ma, mb, mp;
   logic                    mul_ovf;
   logic        [WIDTH:0]   diff;
   logic                    sub_ovf;
   logic signed [WIDTH-1:0] w_nx;
   logic                    accept;
   logic                    last;

   assign last = (k == KW'(NW - 1));

   always_comb begin
      state_nx = state;
      o_busy   = 1'b1;
      o_done   = 1'b0;
      accept   = 1'b0;
      unique case (state)
         S_IDLE: begin
            o_busy = 1'b0;
            if (i_start) begin
               accept   = 1'b1;
               state_nx = S_MUL_G;
            end
         end
         S_MUL_G: state_nx = S_MUL_W;
         S_MUL_W: state_nx = last ? S_DONE : S_MUL_G;
         S_DONE: begin
            o_done   = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // one multiplier, time-shared: gradient term then lr scaling
   always_comb begin
      ma = lr_q;
      mb = g_q;
      if (state == S_MUL_G) begin
         ma = dlto_q[o];
         mb = hd_q[h];
      end
   end

   fxp_mul_sat #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
   ) u_mul (
      .a   (ma),
      .b   (mb),
      .p   (mp),
      .ovf (mul_ovf)
   );

   // one extra bit so the difference never wraps before clamping
   assign diff    = {w_q[k][WIDTH-1], w_q[k]} - {mp[WIDTH-1], mp};
   assign sub_ovf = diff[WIDTH] ^ diff[WIDTH-1];
   assign w_nx    = sub_ovf ? (diff[WIDTH] ? SMIN : SMAX)
                            : diff[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
         k     <= '0;
         h     <= '0;
         o     <= '0;
         lr_q  <= '0;
         g_q   <= '0;
         sat_q <= 1'b0;
         for (int i = 0; i < N_OUT; i++) dlto_q[i] <= '0;
         for (int i = 0; i < N_HL_P; i++) hd_q[i] <= '0;
         for (int i = 0; i < NW; i++) w_q[i] <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            k     <= '0;
            h     <= '0;
            o     <= '0;
            sat_q <= 1'b0;
            lr_q  <= i_lr;
            for (int i = 0; i < N_OUT; i++)
               dlto_q[i] <= i_dlto[i*WIDTH +: WIDTH];
            for (int i = 0; i < N_HL_P; i++)
               hd_q[i] <= i_hd_a[i*WIDTH +: WIDTH];
            for (int i = 0; i < NW; i++)
               w_q[i] <= i_w[i*WIDTH +: WIDTH];
         end
         if (state == S_MUL_G) begin
            g_q   <= mp;
            sat_q <= sat_q | mul_ovf;
         end
         if (state == S_MUL_W) begin
            w_q[k] <= w_nx;
            sat_q  <= sat_q | mul_ovf | sub_ovf;
            if (!last) begin
               k <= k + 1'b1;
               if (o == OW'(N_OUT - 1)) begin
                  o <= '0;
                  h <= h + 1'b1;
               end else begin
                  o <= o + 1'b1;
               end
            end
         end
      end
   end

   for (genvar i = 0; i < NW; i++) begin : g_ow
      assign o_w[i*WIDTH +: WIDTH] = w_q[i];
   end

   assign o_sat = sat_q;

endmodule

// File: tb/tb_weight_update_seq.sv
// Directed bench for weight_update_seq at default parameters.
// Vector table of full passes plus start-hold and mid-pass reset sequences.
module tb_weight_update_seq;

   localparam int NH = 3;
   localparam int NO = 2;
   localparam int W  = 32;
   localparam int NW = NH * NO;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              i_start = 1'b0;
   logic [W-1:0]      i_lr = '0;
   logic [NO*W-1:0]   i_dlto = '0;
   logic [NH*W-1:0]   i_hd_a = '0;
   logic [NW*W-1:0]   i_w = '0;
   logic [NW*W-1:0]   o_w;
   logic              o_busy;
   logic              o_done;
   logic              o_sat;

   typedef struct {
      logic [W-1:0]    lr;
      logic [NO*W-1:0] dlto;
      logic [NH*W-1:0] hd;
      logic [NW*W-1:0] w;
      logic [NW*W-1:0] ew;
      logic            es;
   } vec_t;

   vec_t vt [7];
   int   nvec = 0;
   int   nbad = 0;

   weight_update_seq dut (
      .clk     (clk),
      .rst     (rst),
      .i_start (i_start),
      .i_lr    (i_lr),
      .i_dlto  (i_dlto),
      .i_hd_a  (i_hd_a),
      .i_w     (i_w),
      .o_w     (o_w),
      .o_busy  (o_busy),
      .o_done  (o_done),
      .o_sat   (o_sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [NW*W-1:0] act,
                      input logic [NW*W-1:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic load(input vec_t v);
      i_lr   = v.lr;
      i_dlto = v.dlto;
      i_hd_a = v.hd;
      i_w    = v.w;
   endtask

   task automatic run_pass(input vec_t v, input string nm);
      int lat;
      @(negedge clk);
      load(v);
      i_start = 1'b1;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      // inputs are snapshotted; garbage now must not matter
      i_lr   = $urandom;
      i_dlto = {$urandom, $urandom};
      i_hd_a = {$urandom, $urandom, $urandom};
      i_w    = {$urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom};
      chk({nm, " busy c1"}, o_busy, 1);
      lat = 1;
      while (!o_done && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({nm, " latency"}, lat, 13);
      @(posedge clk);
      #1;
      chk({nm, " busy end"}, o_busy, 0);
      chk({nm, " done end"}, o_done, 0);
      chk({nm, " o_w"}, o_w, v.ew);
      chk({nm, " o_sat"}, o_sat, v.es);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int nd;

      vt[0] = '{lr: 32'h01000000,
                dlto: {32'h0, 32'h00800000},
                hd: {3{32'h01000000}},
                w: '0,
                ew: {32'h0, 32'hFF800000, 32'h0, 32'hFF800000,
                     32'h0, 32'hFF800000},
                es: 1'b0};
      vt[1] = '{lr: 32'h01000000,
                dlto: {32'h01000000, 32'h0},
                hd: {32'h03000000, 32'h02000000, 32'h01000000},
                w: '0,
                ew: {32'hFD000000, 32'h0, 32'hFE000000, 32'h0,
                     32'hFF000000, 32'h0},
                es: 1'b0};
      vt[2] = '{lr: 32'h0,
                dlto: {32'h00400000, 32'hFFC00000},
                hd: {32'h01000000, 32'h02000000, 32'h00800000},
                w: {6{32'h00B33333}},
                ew: {6{32'h00B33333}},
                es: 1'b0};
      vt[3] = '{lr: 32'h01000000,
                dlto: {2{32'h7F000000}},
                hd: {3{32'h7F000000}},
                w: {6{32'h80000001}},
                ew: {6{32'h80000000}},
                es: 1'b1};
      vt[4] = '{lr: 32'h01000000,
                dlto: {32'h0, 32'hFFFFFFFF},
                hd: {3{32'h00800000}},
                w: '0,
                ew: {32'h0, 32'h1, 32'h0, 32'h1, 32'h0, 32'h1},
                es: 1'b0};
      vt[5] = '{lr: 32'h01000000,
                dlto: {2{32'hFF000000}},
                hd: {3{32'h01000000}},
                w: {6{32'h7FFFFFFF}},
                ew: {6{32'h7FFFFFFF}},
                es: 1'b1};
      vt[6] = '{lr: 32'h00800000,
                dlto: {32'h02000000, 32'hFF000000},
                hd: {32'h01000000, 32'h00400000, 32'h02000000},
                w: {6{32'h01000000}},
                ew: {32'h00000000, 32'h01800000, 32'h00C00000,
                     32'h01200000, 32'hFF000000, 32'h02000000},
                es: 1'b0};

      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset o_w", o_w, 0);
      chk("reset busy", o_busy, 0);
      chk("reset done", o_done, 0);
      chk("reset sat", o_sat, 0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 7; i++)
         run_pass(vt[i], $sformatf("vec%0d", i));

      // start held high: passes back to back, 14 cycles apart
      @(negedge clk);
      load(vt[1]);
      i_start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("hold done c%0d", c), o_done,
             (c == 13 || c == 27) ? 1 : 0);
      end
      i_start = 1'b0;
      n = 0;
      while (o_busy && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("hold drain busy", o_busy, 0);
      chk("hold o_w", o_w, vt[1].ew);

      // reset during cycle 5 of a pass
      @(negedge clk);
      load(vt[6]);
      i_start = 1'b1;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst o_w", o_w, 0);
      chk("midrst busy", o_busy, 0);
      chk("midrst done", o_done, 0);
      @(negedge clk);
      rst = 1'b1;
      nd = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (o_done) nd++;
      end
      chk("midrst no done", nd, 0);
      chk("midrst idle o_w", o_w, 0);
      run_pass(vt[6], "after rst");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
